// File: rtl/multi_mips_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and the
// shared ALU/memory datapath (slave).
interface multi_mips_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;

  logic             pcwrite;
  logic             pcwritecond;
  logic             iord;
  logic             memread;
  logic             memwrite;
  logic             irwrite;
  logic             memtoreg;
  logic             regdst;
  logic             regwrite;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       aluop;
  logic [1:0]       pcsource;

  logic [3:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           state, illegal, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsource,
           state, illegal, retired
  );
endinterface

// File: rtl/multi_mips_ctrl.sv
// Multi-cycle MIPS control FSM: Moore control vector, memory wait handshake,
// sticky illegal-opcode trap and a wrapping retired-instruction counter.
//
// state      | meaning
// FETCH  (0) | read instruction at PC, PC+4 into PC when memory is ready
// DECODE (1) | register read, branch target into ALUOut, dispatch on opcode
// MEMADR (2) | lw/sw effective address rs+imm
// MEMRD  (3) | data read at ALUOut, held until memory is ready
// MEMWB  (4) | MDR into rt (retires lw)
// MEMWR  (5) | data write at ALUOut, held until memory is ready (retires sw)
// EXEC   (6) | R-type ALU operation on rs, rt
// ALUWB  (7) | ALUOut into rd (retires R-type)
// BRANCH (8) | rs-rt compare, conditional PC load (retires beq)
// JUMP   (9) | jump target into PC (retires j)
// ADDIEX(10) | rs+imm
// ADDIWB(11) | ALUOut into rt (retires addi)
// TRAP  (12) | unsupported opcode; all strobes off until reset
module multi_mips_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit JUMP_EN     = 1'b1,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst,
  multi_mips_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           state_q;
  state_t           state_d;
  logic             retire;
  logic             rdy;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  // With the wait handshake disabled every memory access completes in one cycle.
  assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    retire          = 1'b0;
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.aluop       = 2'b00;
    bus.pcsource    = 2'b00;

    case (state_q)
      FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = rdy;
        bus.pcwrite = rdy;
        if (rdy) state_d = DECODE;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP_EN ? JUMP : TRAP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
        if (rdy) state_d = MEMWB;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        // the write strobe stays asserted for the whole wait
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        bus.alusrca     = 1'b1;
        bus.aluop       = 2'b01;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = 2'b01;
        retire          = 1'b1;
        state_d         = FETCH;
      end
      JUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = 2'b10;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        bus.regwrite = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
  end

  // Set on the edge that enters TRAP; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_d == TRAP) begin
      illegal_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule
